// File: rtl/vga_timing.sv
// 640x480@60 raster timing: counters, blank/sync decodes, frame tick/count; VGA_CLK_DIV_EN halves pix_en from a 50 MHz clk.
// Counters step one clk after a pix_en edge, decodes are combinational on them; free-running source, no backpressure.
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] column,
  output logic [8:0] row,
  output logic       blank_n,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] h_count_q, h_count_d;
  logic [9:0] v_count_q, v_count_d;
  logic       frame_tick_q, frame_tick_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic       h_last, v_last, frame_wrap;

`ifdef VGA_CLK_DIV_EN
  // Toggle divider: pix_en reads 0 in the first cycle after reset.
  logic div_q, div_d;

  assign div_d = ~div_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q <= 1'b0;
    end else begin
      div_q <= div_d;
    end
  end

  assign pix_en = div_q;
`else
  assign pix_en = 1'b1;
`endif

  assign h_last     = (h_count_q == H_LAST);
  assign v_last     = (v_count_q == V_LAST);
  assign frame_wrap = pix_en & h_last & v_last;

  always_comb begin
    h_count_d     = h_count_q;
    v_count_d     = v_count_q;
    frame_tick_d  = frame_wrap;
    frame_count_d = frame_count_q;
    if (pix_en) begin
      if (!h_last) begin
        h_count_d = h_count_q + 10'd1;
      end else begin
        h_count_d = 10'd0;
        if (!v_last) begin
          v_count_d = v_count_q + 10'd1;
        end else begin
          v_count_d = 10'd0;
        end
      end
    end
    if (frame_wrap) begin
      frame_count_d = frame_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      h_count_q     <= 10'd0;
      v_count_q     <= 10'd0;
      frame_tick_q  <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      frame_tick_q  <= frame_tick_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Decodes come straight off the counter registers so they align with row/column.
  assign column      = h_count_q;
  assign row         = v_count_q[8:0];
  assign blank_n     = (h_count_q < H_VIS) && (v_count_q < V_VIS);
  assign hsync       = !((h_count_q >= H_SYNC_BEG) && (h_count_q < H_SYNC_END));
  assign vsync       = !((v_count_q >= V_SYNC_BEG) && (v_count_q < V_SYNC_END));
  assign frame_tick  = frame_tick_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: full-size instance for line-level decode, reduced-raster instance for frame-level behaviour.
module tb_vga_timing;

`ifdef VGA_CLK_DIV_EN
  localparam int CPS = 2;
`else
  localparam int CPS = 1;
`endif
  // Reduced raster: H 8+2+3+2 = 15, V 4+1+2+1 = 8, 120 strobes per frame.
  localparam int SF = 120;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pix_en, blank_n, hsync, vsync, frame_tick;
  logic [9:0] column;
  logic [8:0] row;
  logic [7:0] frame_count;
  logic       s_pix_en, s_blank_n, s_hsync, s_vsync, s_frame_tick;
  logic [9:0] s_column;
  logic [8:0] s_row;
  logic [7:0] s_frame_count;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int clk_used = 0;

  always #5 clk = ~clk;

  vga_timing dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .column(column), .row(row),
    .blank_n(blank_n), .hsync(hsync), .vsync(vsync),
    .frame_tick(frame_tick), .frame_count(frame_count)
  );

  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_s (
    .clk(clk), .rst(rst), .pix_en(s_pix_en), .column(s_column), .row(s_row),
    .blank_n(s_blank_n), .hsync(s_hsync), .vsync(s_vsync),
    .frame_tick(s_frame_tick), .frame_count(s_frame_count)
  );

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Advance to the sample point after the next counter step.
  task automatic strobe();
    logic p;
    int   n;
    n = 0;
    do begin
      p = pix_en;
      @(negedge clk);
      n++;
      clk_used++;
    end while (!p && n < 4);
    if (!p) begin
      chk_cnt++;
      $display("FAIL strobe_timeout: pix_en stayed %0d for %0d clk, required 1", p, n);
    end
  endtask

  task automatic test_reset();
    do_reset(3);
    chk_cnt++; if (column !== 10'd0) $display("FAIL reset_column: got %0d required 0", column); else pass_cnt++;
    chk_cnt++; if (row !== 9'd0) $display("FAIL reset_row: got %0d required 0", row); else pass_cnt++;
    chk_cnt++; if (blank_n !== 1'b1) $display("FAIL reset_blank_n: got %b required 1", blank_n); else pass_cnt++;
    chk_cnt++; if (hsync !== 1'b1 || vsync !== 1'b1) $display("FAIL reset_sync: got h=%b v=%b required 1/1", hsync, vsync); else pass_cnt++;
    chk_cnt++; if (frame_tick !== 1'b0) $display("FAIL reset_frame_tick: got %b required 0", frame_tick); else pass_cnt++;
    chk_cnt++; if (frame_count !== 8'd0) $display("FAIL reset_frame_count: got %0d required 0", frame_count); else pass_cnt++;
    chk_cnt++; if (pix_en !== (CPS == 1)) $display("FAIL reset_pix_en: got %b required %0d", pix_en, (CPS == 1)); else pass_cnt++;
  endtask

  task automatic test_pix_en();
    int   err;
    logic prev;
    err = 0;
    do_reset(1);
    prev = pix_en;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (CPS == 2 && pix_en !== ~prev) err++;
      if (CPS == 1 && pix_en !== 1'b1) err++;
      prev = pix_en;
    end
    chk_cnt++; if (err !== 0) $display("FAIL pix_en_pattern: got %0d bad cycles required 0", err); else pass_cnt++;
  endtask

  task automatic test_horizontal();
    int col_err, row_err, bl_err, vs_err, hs_cnt, first_bl, first_hs, last_hs;
    col_err = 0; row_err = 0; bl_err = 0; vs_err = 0; hs_cnt = 0;
    first_bl = -1; first_hs = -1; last_hs = -1;
    do_reset(1);
    clk_used = 0;
    for (int i = 0; i < 800; i++) begin
      if (column !== 10'(i)) col_err++;
      if (row !== 9'd0) row_err++;
      if (blank_n !== (i < 640)) bl_err++;
      if (vsync !== 1'b1) vs_err++;
      if (blank_n === 1'b0 && first_bl < 0) first_bl = int'(column);
      if (hsync === 1'b0) begin
        hs_cnt++;
        if (first_hs < 0) first_hs = int'(column);
        last_hs = int'(column);
      end
      strobe();
    end
    chk_cnt++; if (col_err !== 0) $display("FAIL h_column_seq: got %0d bad strobes required 0", col_err); else pass_cnt++;
    chk_cnt++; if (row_err !== 0) $display("FAIL h_row_hold: got %0d bad strobes required 0", row_err); else pass_cnt++;
    chk_cnt++; if (bl_err !== 0) $display("FAIL h_blank_pattern: got %0d bad strobes required 0", bl_err); else pass_cnt++;
    chk_cnt++; if (first_bl !== 640) $display("FAIL h_blank_fall: got column %0d required 640", first_bl); else pass_cnt++;
    chk_cnt++; if (hs_cnt !== 96) $display("FAIL hsync_width: got %0d required 96", hs_cnt); else pass_cnt++;
    chk_cnt++; if (first_hs !== 656 || last_hs !== 751) $display("FAIL hsync_span: got %0d..%0d required 656..751", first_hs, last_hs); else pass_cnt++;
    chk_cnt++; if (vs_err !== 0) $display("FAIL h_vsync_idle: got %0d low strobes required 0", vs_err); else pass_cnt++;
    chk_cnt++; if (column !== 10'd0 || row !== 9'd1) $display("FAIL h_wrap: got (%0d,%0d) required (1,0)", row, column); else pass_cnt++;
    chk_cnt++; if (clk_used !== 800 * CPS) $display("FAIL line_clks: got %0d required %0d", clk_used, 800 * CPS); else pass_cnt++;
  endtask

  task automatic test_vertical();
    int mh, mv, pos_err, bl_err, hs_err, vs_err, vblank_err, vs_low;
    mh = 0; mv = 0; pos_err = 0; bl_err = 0; hs_err = 0; vs_err = 0; vblank_err = 0; vs_low = 0;
    do_reset(1);
    for (int i = 0; i < SF; i++) begin
      if (s_column !== 10'(mh) || s_row !== 9'(mv)) pos_err++;
      if (s_blank_n !== (mh < 8 && mv < 4)) bl_err++;
      if (s_hsync !== !(mh >= 10 && mh < 13)) hs_err++;
      if (s_vsync !== !(mv >= 5 && mv < 7)) vs_err++;
      if (mv >= 4 && s_blank_n !== 1'b0) vblank_err++;
      if (s_vsync === 1'b0) vs_low++;
      strobe();
      if (mh == 14) begin mh = 0; mv = (mv == 7) ? 0 : mv + 1; end
      else mh++;
    end
    chk_cnt++; if (pos_err !== 0) $display("FAIL v_position: got %0d bad strobes required 0", pos_err); else pass_cnt++;
    chk_cnt++; if (bl_err !== 0) $display("FAIL v_blank_pattern: got %0d bad strobes required 0", bl_err); else pass_cnt++;
    chk_cnt++; if (vblank_err !== 0) $display("FAIL v_blank_rows: got %0d visible strobes required 0", vblank_err); else pass_cnt++;
    chk_cnt++; if (hs_err !== 0) $display("FAIL v_hsync_pattern: got %0d bad strobes required 0", hs_err); else pass_cnt++;
    chk_cnt++; if (vs_err !== 0) $display("FAIL v_vsync_rows: got %0d bad strobes required 0", vs_err); else pass_cnt++;
    chk_cnt++; if (vs_low !== 30) $display("FAIL vsync_width: got %0d required 30", vs_low); else pass_cnt++;
  endtask

  task automatic test_frame_wrap();
    int   ticks, tick_long, n_str;
    logic prev_tick, done;
    ticks = 0;
    do_reset(1);
    for (int i = 0; i < SF - 1; i++) begin
      if (s_frame_tick === 1'b1) ticks++;
      strobe();
    end
    chk_cnt++; if (ticks !== 0) $display("FAIL early_tick: got %0d ticks required 0", ticks); else pass_cnt++;
    chk_cnt++; if (s_column !== 10'd14 || s_row !== 9'd7) $display("FAIL pre_wrap_pos: got (%0d,%0d) required (7,14)", s_row, s_column); else pass_cnt++;
    strobe();
    chk_cnt++; if (s_column !== 10'd0 || s_row !== 9'd0 || s_frame_tick !== 1'b1) $display("FAIL wrap_tick: got (%0d,%0d) tick=%b required (0,0) tick=1", s_row, s_column, s_frame_tick); else pass_cnt++;
    chk_cnt++; if (s_frame_count !== 8'd1) $display("FAIL frame_count_1: got %0d required 1", s_frame_count); else pass_cnt++;
    n_str = 0; ticks = 0; tick_long = 0; prev_tick = 1'b1; done = 1'b0;
    for (int c = 0; c < 255 * SF * CPS + 10; c++) begin
      if (pix_en === 1'b1) n_str++;
      @(negedge clk);
      if (s_frame_tick === 1'b1) begin
        ticks++;
        if (prev_tick) tick_long++;
      end
      prev_tick = s_frame_tick;
      if (s_frame_tick === 1'b1 && s_frame_count === 8'd0) begin
        done = 1'b1;
        break;
      end
    end
    chk_cnt++; if (done !== 1'b1) $display("FAIL frame_count_wrap: got count %0d required 0 within budget", s_frame_count); else pass_cnt++;
    chk_cnt++; if (n_str !== 255 * SF) $display("FAIL wrap_strobes: got %0d required %0d", n_str, 255 * SF); else pass_cnt++;
    chk_cnt++; if (ticks !== 255) $display("FAIL tick_count: got %0d required 255", ticks); else pass_cnt++;
    chk_cnt++; if (tick_long !== 0) $display("FAIL tick_width: got %0d multi-clk ticks required 0", tick_long); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (s_frame_tick !== 1'b0) $display("FAIL tick_clear: got %b required 0", s_frame_tick); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    do_reset(1);
    for (int i = 0; i < 2 * SF + 65; i++) strobe();
    chk_cnt++; if (s_frame_count !== 8'd2 || s_column !== 10'd5 || s_row !== 9'd4) $display("FAIL pre_reset_state: got cnt=%0d (%0d,%0d) required cnt=2 (4,5)", s_frame_count, s_row, s_column); else pass_cnt++;
    chk_cnt++; if (column !== 10'd305 || row !== 9'd0) $display("FAIL pre_reset_line: got (%0d,%0d) required (0,305)", row, column); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk_cnt++; if (s_column !== 10'd0 || s_row !== 9'd0 || s_frame_tick !== 1'b0 || s_frame_count !== 8'd0) $display("FAIL mid_reset_small: got (%0d,%0d) tick=%b cnt=%0d required (0,0) 0 0", s_row, s_column, s_frame_tick, s_frame_count); else pass_cnt++;
    chk_cnt++; if (column !== 10'd0 || row !== 9'd0 || blank_n !== 1'b1 || hsync !== 1'b1) $display("FAIL mid_reset_full: got (%0d,%0d) blank_n=%b hsync=%b required (0,0) 1 1", row, column, blank_n, hsync); else pass_cnt++;
    for (int i = 0; i < 17; i++) strobe();
    chk_cnt++; if (s_column !== 10'd2 || s_row !== 9'd1) $display("FAIL resume_small: got (%0d,%0d) required (1,2)", s_row, s_column); else pass_cnt++;
    chk_cnt++; if (column !== 10'd17 || row !== 9'd0) $display("FAIL resume_full: got (%0d,%0d) required (0,17)", row, column); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_pix_en();
    test_horizontal();
    test_vertical();
    test_frame_wrap();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing source for the 640x480 @ 60 Hz display path. Generates the pixel coordinates (`row`, `column`), the active-video qualifier (`blank_n`) and the negative-polarity sync pulses. These feed the colour generator and the VGA DAC/connector directly. It also emits a per-frame tick and a frame counter that the game FSM uses as its animation and fall-rate time base.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)

Ports:
- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst`  in  1  reset. Synchronous and active-low: the block resets on a rising `clk` edge while `rst`=0.
- `pix_en`  out  1  pixel-advance strobe. The counters step only on cycles where it is 1.
- `column`  out  10  horizontal count, 0..H_TOTAL-1
- `row`  out  9  `v_count[8:0]`. Truncated during vertical blanking, which is harmless because `blank_n`=0 there.
- `blank_n`  out  1  1 when the current pixel is in the visible region
- `hsync`  out  1  horizontal sync, active-low
- `vsync`  out  1  vertical sync, active-low
- `frame_tick`  out  1  one-`clk` pulse at the start of each frame
- `frame_count`  out  8  frames since reset, wrapping

## Operation
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
- Internal counters are `h_count` (10 bits) and `v_count` (10 bits). `column` = `h_count`; `row` = `v_count[8:0]`.
- On a `clk` edge with `pix_en`=1:
  - If `h_count` < H_TOTAL-1, `h_count` increments and `v_count` is unchanged.
  - Otherwise `h_count` becomes 0.
    - If `v_count` < V_TOTAL-1, `v_count` increments.
    - Otherwise `v_count` becomes 0 and the frame wraps.
- Decodes are combinational from the counter registers, so they have zero skew relative to `row`/`column`:
  - `blank_n` = (`h_count` < H_ACTIVE) && (`v_count` < V_ACTIVE).
  - `hsync` = 0 iff H_ACTIVE+H_FP ≤ `h_count` < H_ACTIVE+H_FP+H_SYNC, i.e. columns 656..751.
  - `vsync` = 0 iff V_ACTIVE+V_FP ≤ `v_count` < V_ACTIVE+V_FP+V_SYNC, i.e. rows 490..491.
- `frame_tick` is a register. It is set to 1 on the edge where the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0), and cleared on the next `clk` edge.
- `frame_count` is a register. It increments on that same wrap edge and wraps from 255 to 0.
- Reset (`rst`=0 at an edge) sets `h_count`=0, `v_count`=0, `frame_tick`=0, `frame_count`=0 and the divider flop to 0. This applies at any point, including mid-line or mid-frame.
- Resulting output values after a reset edge: `column`=0, `row`=0, `blank_n`=1, `hsync`=1, `vsync`=1, `frame_tick`=0, `frame_count`=0.
- Reset has priority over counting on the same edge.

## Timing
- Counter latency: a counter step becomes visible one `clk` after the `pix_en`=1 edge.
- Decoded outputs change in the same cycle as the counters.
- `frame_tick` rises in the same cycle that (`row`,`column`) first reads (0,0). It lasts exactly one `clk`, even when `pix_en` has a divided rate.
- Line period is H_TOTAL pixel strobes. Frame period is H_TOTAL×V_TOTAL = 420000 pixel strobes.
- Downstream stages that register colour add their own delay. This block performs no compensation.

## Configuration
- `VGA_CLK_DIV_EN` defined:
  - `clk` is 50 MHz.
  - An internal toggle flop (reset to 0) drives `pix_en`, so `pix_en` = 0,1,0,1… starting at 0 in the first cycle after reset.
  - Counters advance every second `clk`, and one line takes 1600 `clk` cycles.
- `VGA_CLK_DIV_EN` undefined:
  - `clk` is the 25 MHz pixel clock.
  - `pix_en` is tied to 1, and one line takes 800 `clk` cycles.

## Test plan
- Reset values: hold `rst`=0 for 3 cycles, then release. Required: `column`=0, `row`=0, `blank_n`=1, `hsync`=1, `vsync`=1, `frame_count`=0. With the divider, `pix_en` is 0 in the first cycle after release.
- Horizontal decode: run one line. Required:
  - `blank_n` falls when `column`=640.
  - `hsync` is low for exactly 96 strobes, over columns 656..751.
  - `column` wraps 799→0 with `row` going 0→1.
- Vertical decode: run to line 480. Required:
  - `blank_n`=0 for every column of rows 480..524.
  - `vsync` is low only on rows 490 and 491, for 1600 strobes total.
- Frame wrap: run 420000 strobes from reset. Required: `frame_tick` is a single-cycle pulse coincident with (0,0), and `frame_count`=1. Run 256 frames in total and `frame_count` wraps to 0.
- Mid-frame reset: assert `rst` at `column`=300, `row`=200. Required: on the next cycle the outputs are (0,0), `frame_tick`=0 and `frame_count`=0, and counting resumes normally after release.
- Divider build (`VGA_CLK_DIV_EN`): required 1600 `clk` per line, `pix_en` alternating every cycle, and `frame_tick` still one `clk` wide.
